// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO plus a three-state issue FSM that feeds uart_tx one byte at a time,
// waiting for uart_tx's done pulse before starting the next frame.
module uart_tx_fifo_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Wr_En,
  input  logic [7:0]        i_Wr_Byte,
  input  logic              i_Clr_Ovf,
  input  logic              i_Tx_Done,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  output logic              o_Busy,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              dv_q, dv_d;
  logic              busy_q, busy_d;
  logic [7:0]        byte_q, byte_d;
  logic [7:0]        mem_q [DEPTH];
  logic              wr_acc;
  logic              pop;

  // Full/empty come from the registered flags only, so a write while full is
  // dropped even when a pop lands on the same edge.
  always_comb begin
    wr_acc   = i_Wr_En && !full_q;
    pop      = (state_q == IDLE) && !empty_q;
    state_d  = state_q;
    dv_d     = 1'b0;
    busy_d   = busy_q;
    byte_d   = byte_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (pop) begin
          byte_d   = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + 1'b1;
          dv_d     = 1'b1;
          busy_d   = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (i_Tx_Done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);

    if (i_Wr_En && full_q) ovf_d = 1'b1;
    else if (i_Clr_Ovf)    ovf_d = 1'b0;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      dv_q     <= 1'b0;
      busy_q   <= 1'b0;
      byte_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      dv_q     <= dv_d;
      busy_q   <= busy_d;
      byte_q   <= byte_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_Clock) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_Wr_Byte;
  end

  assign o_Tx_DV    = dv_q;
  assign o_Tx_Byte  = byte_q;
  assign o_Busy     = busy_q;
  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder; uart_tx's done pulse is driven by hand.
module tb_uart_tx_fifo_feeder;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, clr_ovf, tx_done;
  logic [7:0] wr_byte;
  logic       dv, busy, full, empty, ovf;
  logic [7:0] tx_byte;
  logic [4:0] count;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_feeder #(.DEPTH(16), .ADDR_W(4)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Wr_En(wr_en), .i_Wr_Byte(wr_byte),
    .i_Clr_Ovf(clr_ovf), .i_Tx_Done(tx_done), .o_Tx_DV(dv), .o_Tx_Byte(tx_byte),
    .o_Busy(busy), .o_Full(full), .o_Empty(empty), .o_Count(count),
    .o_Overflow(ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1; wr_byte = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic burst(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_byte = base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Enter in WAIT: done pulse, one idle cycle, then the next issue.
  task automatic send_next(input logic [7:0] exp);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_dv", dv, 0);
    tick();
    chk("issue_dv", dv, 1);
    chk("issue_byte", tx_byte, exp);
    tick();
    chk("dv_one_cycle", dv, 0);
  endtask

  task automatic finish_frame;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("done_busy", busy, 0);
  endtask

  task automatic chk_reset_vals;
    chk("rst_dv", dv, 0);
    chk("rst_byte", tx_byte, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_byte = 8'h00; clr_ovf = 1'b0; tx_done = 1'b0;
    repeat (2) tick();
    chk_reset_vals();
    rst_n = 1'b1;
    tick();

    // Single byte: DV one cycle after the write edge, done in ISSUE ignored
    wr(8'hAB);
    chk("sb_empty", empty, 0);
    chk("sb_count", count, 1);
    chk("sb_dv_early", dv, 0);
    tx_done = 1'b0;
    tick();
    chk("sb_dv", dv, 1);
    chk("sb_byte", tx_byte, 8'hAB);
    chk("sb_busy", busy, 1);
    chk("sb_count_pop", count, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("sb_dv_drop", dv, 0);
    chk("sb_issue_done_ignored", busy, 1);
    repeat (3) tick();
    chk("sb_wait_busy", busy, 1);
    finish_frame();
    tick();
    chk("sb_byte_held", tx_byte, 8'hAB);
    chk("sb_no_reissue", dv, 0);

    // Burst 01..05
    burst(8'h01, 5);
    chk("burst_peak", count, 4);
    chk("burst_first", tx_byte, 8'h01);
    for (int i = 2; i <= 5; i++) send_next(8'(i));
    finish_frame();
    chk("burst_empty", empty, 1);
    chk("burst_ovf", ovf, 0);

    // Full / overflow with the FSM parked in WAIT
    wr(8'h20);
    tick();
    tick();
    chk("blk_busy", busy, 1);
    burst(8'h30, 16);
    chk("full_flag", full, 1);
    chk("full_count", count, 16);
    chk("full_no_ovf", ovf, 0);
    wr(8'hEE);
    chk("ovf_set", ovf, 1);
    chk("ovf_count", count, 16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", ovf, 0);
    wr_en = 1'b1; wr_byte = 8'hEE; clr_ovf = 1'b1;
    tick();
    wr_en = 1'b0; clr_ovf = 1'b0;
    chk("ovf_set_wins", ovf, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr2", ovf, 0);
    finish_frame();
    chk("full_idle", full, 1);
    wr(8'hEE);
    chk("fullpop_dv", dv, 1);
    chk("fullpop_byte", tx_byte, 8'h30);
    chk("fullpop_count", count, 15);
    chk("fullpop_ovf", ovf, 1);
    chk("fullpop_full", full, 0);
    tick();
    for (int i = 1; i < 16; i++) send_next(8'h30 + 8'(i));
    finish_frame();
    chk("drain_empty", empty, 1);
    chk("drain_last", tx_byte, 8'h3F);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;

    // Pointer wrap: 3 rounds of 12
    for (int r = 0; r < 3; r++) begin
      burst(8'h80 + 8'(r * 16), 12);
      chk("wrap_peak", count, 11);
      chk("wrap_first", tx_byte, 8'h80 + 8'(r * 16));
      for (int i = 1; i < 12; i++) send_next(8'h80 + 8'(r * 16 + i));
      finish_frame();
      chk("wrap_empty", empty, 1);
      chk("wrap_ovf", ovf, 0);
    end

    // Write and pop on the same edge with count=1
    wr(8'h51);
    wr(8'h52);
    chk("sim_count", count, 1);
    chk("sim_dv", dv, 1);
    chk("sim_byte", tx_byte, 8'h51);
    tick();
    send_next(8'h52);
    finish_frame();
    chk("sim_end_count", count, 0);

    // Reset in the middle of byte 2 of 4
    burst(8'h61, 4);
    chk("rmf_count", count, 3);
    send_next(8'h62);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    tick();
    #2 rst_n = 1'b1;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("late_done_busy", busy, 0);
    chk("late_done_dv", dv, 0);
    chk("late_done_empty", empty, 1);
    wr(8'h3B);
    chk("post_rst_count", count, 1);
    tick();
    chk("post_rst_dv", dv, 1);
    chk("post_rst_byte", tx_byte, 8'h3B);
    tick();
    finish_frame();
    chk("post_rst_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
